// File: rtl/instr_sequencer.sv
// Instruction sequencer: steps through a small instruction buffer and
// strobes decoded fields into a register/ALU stage.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   load_en/addr/data        buffer write (honoured only in IDLE or HALT)
//   start                    begin a run from pc 0 (IDLE or HALT only)
//   step_mode, step          single-step control, checked in GAP
//   ALU_Operation, Rs/Rt/Rd  decoded fields of the current instruction
//   execute                  write strobe, high EXEC_CYCLES cycles per instr
//   pc                       current or next instruction index
//   busy, halted             status (FETCH/ISSUE/GAP, HALT)
//   issue_count              instructions completed since start (saturating)
module instr_sequencer #(
    parameter int DEPTH       = 16,
    parameter int EXEC_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en,
    input  logic [3:0]  load_addr,
    input  logic [15:0] load_data,
    input  logic        start,
    input  logic        step_mode,
    input  logic        step,
    output logic [2:0]  ALU_Operation,
    output logic [3:0]  Rs,
    output logic [3:0]  Rt,
    output logic [3:0]  Rd,
    output logic        execute,
    output logic [3:0]  pc,
    output logic        busy,
    output logic        halted,
    output logic [7:0]  issue_count
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] ISSUE = 3'd2;
    localparam logic [2:0] GAP   = 3'd3;
    localparam logic [2:0] HALT  = 3'd4;

    localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

    logic [2:0]    state;
    logic [CW-1:0] exec_cnt;
    logic [15:0]   mem [DEPTH];
    logic [15:0]   word;
    logic          can_load;
    logic          last_exec;
    logic          last_pc;
    logic          gap_exit;

    assign word      = mem[pc];
    assign can_load  = (state == IDLE) || (state == HALT);
    assign last_exec = (exec_cnt == CW'(EXEC_CYCLES - 1));
    assign last_pc   = (pc == 4'(DEPTH - 1));
    assign gap_exit  = !step_mode || step;

    // execute is decoded straight from state so an asynchronous reset
    // removes the strobe immediately rather than at the next edge.
    assign execute = (state == ISSUE);
    assign busy    = (state == FETCH) || (state == ISSUE) || (state == GAP);
    assign halted  = (state == HALT);

    // Buffer has no reset so programs survive a reset pulse.
    always_ff @(posedge clk) begin
        if (load_en && can_load && (int'(load_addr) < DEPTH))
            mem[load_addr] <= load_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            exec_cnt      <= '0;
            pc            <= 4'd0;
            issue_count   <= 8'd0;
            ALU_Operation <= 3'd0;
            Rs            <= 4'd0;
            Rt            <= 4'd0;
            Rd            <= 4'd0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        state       <= FETCH;
                        pc          <= 4'd0;
                        issue_count <= 8'd0;
                    end
                end
                FETCH: begin
                    // A halt word leaves the fields showing the last
                    // instruction so HALT holds every output.
                    if (word[15]) begin
                        state <= HALT;
                    end else begin
                        state         <= ISSUE;
                        exec_cnt      <= '0;
                        ALU_Operation <= word[14:12];
                        Rs            <= word[11:8];
                        Rt            <= word[7:4];
                        Rd            <= word[3:0];
                    end
                end
                ISSUE: begin
                    if (last_exec)
                        state <= GAP;
                    else
                        exec_cnt <= exec_cnt + 1'b1;
                end
                GAP: begin
                    if (gap_exit) begin
                        if (issue_count != 8'hFF)
                            issue_count <= issue_count + 8'd1;
                        if (last_pc) begin
                            state <= HALT;
                        end else begin
                            state <= FETCH;
                            pc    <= pc + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter DEPTH, default 16: number of instruction-buffer entries; PC width is 4 bits.
REQ-002 Parameter EXEC_CYCLES, default 2: clock cycles for which execute is held high per instruction.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 load_en  input  1  when high, write load_data into buffer entry load_addr.
REQ-006 load_addr  input  4  buffer write address.
REQ-007 load_data  input  16  instruction word: [15]=halt, [14:12]=op, [11:8]=rs, [7:4]=rt, [3:0]=rd.
REQ-008 start  input  1  level sampled each cycle; begins a run from PC 0.
REQ-009 step_mode  input  1  when high, pause after each instruction until step is seen.
REQ-010 step  input  1  advances one instruction in step mode.
REQ-011 ALU_Operation  output  3  op field to the register/ALU stage.
REQ-012 Rs, Rt, Rd  output  4 each  register addresses to the register/ALU stage.
REQ-013 execute  output  1  write-enable strobe to the register/ALU stage.
REQ-014 pc  output  4  index of the current or next instruction.
REQ-015 busy  output  1  high in states FETCH, ISSUE and GAP.
REQ-016 halted  output  1  high in state HALT.
REQ-017 issue_count  output  8  number of instructions completed since the last start.

Function
REQ-018 The block SHALL implement states IDLE, FETCH, ISSUE, GAP and HALT.
REQ-019 IDLE SHALL transition to FETCH when start=1, and SHALL clear pc and issue_count in that same cycle.
REQ-020 FETCH SHALL last exactly 1 cycle and register mem[pc] into the instruction register.
REQ-021 From FETCH, the state SHALL become HALT if halt bit [15]=1 (execute is never asserted); otherwise it SHALL become ISSUE.
REQ-022 In ISSUE, execute SHALL be 1 for exactly EXEC_CYCLES consecutive cycles, and ALU_Operation, Rs, Rt and Rd SHALL stay stable throughout.
REQ-023 After ISSUE, the state SHALL enter GAP, in which execute=0 for at least 1 cycle; the fields SHALL hold their last values.
REQ-024 On GAP exit, issue_count SHALL increment, saturating at 255.
REQ-025 On GAP exit, pc SHALL increment if pc<DEPTH-1; if pc=DEPTH-1, the state SHALL go to HALT with no wrap-around.
REQ-026 With step_mode=0, GAP SHALL exit to FETCH after 1 cycle; with step_mode=1, GAP SHALL hold until a cycle with step=1 and then exit.
REQ-027 Per-instruction latency SHALL be 1+EXEC_CYCLES+1 cycles (4 at the default) when step_mode=0.
REQ-028 HALT SHALL hold all outputs; start=1 in HALT SHALL behave exactly as start in IDLE.
REQ-029 start SHALL be ignored while busy=1.
REQ-030 load_en SHALL write only in IDLE or HALT and SHALL be ignored while busy=1.
REQ-031 A write and start in the same IDLE cycle SHALL both take effect; the following FETCH SHALL see the newly written word.
REQ-032 step while step_mode=0, or outside GAP, SHALL be ignored.

Reset
REQ-033 rst=1 SHALL immediately force state IDLE, execute=0, pc=0, issue_count=0, busy=0, halted=0, and ALU_Operation, Rs, Rt, Rd = 0.
REQ-034 Buffer contents SHALL NOT be cleared by rst and SHALL be retained across resets.
REQ-035 rst asserted during ISSUE SHALL drop execute in the same cycle with no further register write issued; after rst is released, the block SHALL wait in IDLE for start.

Verification
REQ-036 Load mem[0]=0x00F1 (ADD rs0,rt15,rd1) and mem[1]=0x8000, then start -> execute high for 2 cycles with op=0, Rs=0, Rt=15, Rd=1; then HALT with issue_count=1 and pc=1.
REQ-037 Load 3 non-halt words and mem[3] halt, then start -> 3 execute pulses spaced 4 cycles apart, halted=1, issue_count=3.
REQ-038 Fill all 16 entries with non-halt words, then start -> 16 pulses, then HALT with pc=15 (no wrap) and issue_count=16.
REQ-039 step_mode=1 with 2 words -> after the first pulse the block holds in GAP (busy=1, execute=0) until step=1; then the second pulse follows 2 cycles later.
REQ-040 Assert rst in the 1st execute cycle -> execute=0 in the same cycle; after release, IDLE with pc=0 and issue_count=0, and buffer contents intact (restart reproduces REQ-036).
REQ-041 Attempt load_en and start while busy -> buffer and sequence unchanged; in HALT, load_en+start together -> the new mem[0] is executed.
